// File: rtl/bool_sweep_pkg.sv
// bool_sweep_pkg: shared state encoding and settle-counter width for the sweeper.
package bool_sweep_pkg;
    localparam int SW = 4;
    typedef enum logic [2:0] {IDLE, DRIVE, SAMPLE, WAIT_STEP, DONE} state_t;
endpackage

// File: rtl/sweep_vec_counter.sv
// sweep_vec_counter: stimulus vector counter with all-ones detect, plus settle down-counter.
module sweep_vec_counter
    import bool_sweep_pkg::*;
#(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    input  logic            load,
    input  logic            dec,
    input  logic [SW-1:0]   load_val,
    output logic [N_IN-1:0] vec,
    output logic            last,
    output logic            zero
);
    logic [SW-1:0] settle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec    <= '0;
            settle <= '0;
        end else begin
            vec    <= clr ? '0 : inc ? vec + 1'b1 : vec;
            settle <= load ? load_val : (dec && settle != '0) ? settle - 1'b1 : settle;
        end
    end

    assign last = &vec;
    assign zero = settle == '0;
endmodule

// File: rtl/bool_equiv_sweeper.sv
// bool_equiv_sweeper: exhaustive equivalence sweep of two combinational functions,
// counting mismatches and capturing the first failing vector.
module bool_equiv_sweeper
    import bool_sweep_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1,
    parameter int CW     = N_IN + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            step_mode,
    input  logic            step,
    output logic [N_IN-1:0] vec_out,
    input  logic            s_a,
    input  logic            s_b,
    output logic            busy,
    output logic            done,
    output logic            equal,
    output logic [CW-1:0]   mismatch_cnt,
    output logic            first_valid,
    output logic [N_IN-1:0] first_vec
);
    localparam logic [SW-1:0] SLOAD = SW'(SETTLE - 1);

    state_t state;
    logic   step_q, last, zero, clr, inc, dec, diff;

    always_comb begin
        clr  = state == IDLE && start;
        inc  = (state == SAMPLE && !last && !step_q) || (state == WAIT_STEP && step);
        dec  = state == DRIVE;
        diff = s_a ^ s_b;
    end

    sweep_vec_counter #(.N_IN(N_IN)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .inc      (inc),
        .load     (clr || inc),
        .dec      (dec),
        .load_val (SLOAD),
        .vec      (vec_out),
        .last     (last),
        .zero     (zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            step_q       <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            equal        <= 1'b0;
            mismatch_cnt <= '0;
            first_valid  <= 1'b0;
            first_vec    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    mismatch_cnt <= '0;
                    first_valid  <= 1'b0;
                    first_vec    <= '0;
                    equal        <= 1'b0;
                    step_q       <= step_mode;
                    busy         <= 1'b1;
                    state        <= DRIVE;
                end
                DRIVE: if (zero) state <= SAMPLE;
                SAMPLE: begin
                    if (diff) begin
                        mismatch_cnt <= mismatch_cnt + CW'(1);
                        if (!first_valid) begin
                            first_vec   <= vec_out;
                            first_valid <= 1'b1;
                        end
                    end
                    // equal must already be valid in the done cycle, so fold in this sample
                    if (last) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        equal <= mismatch_cnt == '0 && !diff;
                    end else begin
                        state <= step_q ? WAIT_STEP : DRIVE;
                    end
                end
                WAIT_STEP: if (step) state <= DRIVE;
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bool_equiv_sweeper.sv
// tb_bool_equiv_sweeper: directed checks of sweep order, mismatch capture, step mode,
// async reset, start-while-busy and a 3-input/3-settle configuration.
module tb_bool_equiv_sweeper;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic start = 1'b0, step_mode = 1'b0, step = 1'b0;
    logic fsel = 1'b0;
    logic [1:0] vec_out;
    logic s_a, s_b, busy, done, equal, first_valid;
    logic [2:0] mismatch_cnt;
    logic [1:0] first_vec;

    logic start2 = 1'b0;
    logic [2:0] vec2, first_vec2;
    logic s_a2, s_b2, busy2, done2, equal2, first_valid2;
    logic [3:0] cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // x = vec[1], y = vec[0]; fsel 0: A=(x|~y)|(~x&~y), B=x|~y; fsel 1: A=x|y, B=x&y
    assign s_a = fsel ? (vec_out[1] | vec_out[0])
                      : ((vec_out[1] | ~vec_out[0]) | (~vec_out[1] & ~vec_out[0]));
    assign s_b = fsel ? (vec_out[1] & vec_out[0]) : (vec_out[1] | ~vec_out[0]);

    assign s_a2 = (32'(vec2[2]) + 32'(vec2[1]) + 32'(vec2[0])) >= 2;
    assign s_b2 = (vec2[2] & vec2[1]) | (vec2[2] & vec2[0]) | (vec2[1] & vec2[0]);

    bool_equiv_sweeper #(.N_IN(2), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .vec_out(vec_out), .s_a(s_a), .s_b(s_b), .busy(busy), .done(done), .equal(equal),
        .mismatch_cnt(mismatch_cnt), .first_valid(first_valid), .first_vec(first_vec)
    );

    bool_equiv_sweeper #(.N_IN(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start2), .step_mode(1'b0), .step(1'b0),
        .vec_out(vec2), .s_a(s_a2), .s_b(s_b2), .busy(busy2), .done(done2), .equal(equal2),
        .mismatch_cnt(cnt2), .first_valid(first_valid2), .first_vec(first_vec2)
    );

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_out, busy, done, equal, mismatch_cnt, first_valid, first_vec} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %b exp 0",
                     {vec_out, busy, done, equal, mismatch_cnt, first_valid, first_vec});
        end
        checks++;
        if ({vec2, busy2, done2, equal2, cnt2, first_valid2, first_vec2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_n3 got %b exp 0",
                     {vec2, busy2, done2, equal2, cnt2, first_valid2, first_vec2});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_equal_freerun();
        int cyc;
        fsel = 1'b0;
        step_mode = 1'b0;
        do_start();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL fr_busy got %b exp 1", busy); end
        cyc = 1;
        while (!done && cyc < 100) begin
            checks++;
            if (vec_out !== 2'((cyc - 1) / 2)) begin
                errors++;
                $display("FAIL fr_vec cycle %0d got %0d exp %0d", cyc, vec_out, (cyc - 1) / 2);
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 9) begin errors++; $display("FAIL fr_done_cycle got %0d exp 9", cyc); end
        checks++;
        if ({equal, mismatch_cnt, first_valid} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL fr_result got eq=%b cnt=%0d fv=%b exp eq=1 cnt=0 fv=0",
                     equal, mismatch_cnt, first_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, done, equal} !== 3'b001) begin
            errors++;
            $display("FAIL fr_after got busy=%b done=%b eq=%b exp 0 0 1", busy, done, equal);
        end
    endtask

    task automatic test_mismatch();
        int cyc;
        fsel = 1'b1;
        do_start();
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 9) begin errors++; $display("FAIL mm_done_cycle got %0d exp 9", cyc); end
        checks++;
        if ({mismatch_cnt, first_valid, first_vec, equal} !== {3'd2, 1'b1, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL mm_result got cnt=%0d fv=%b fvec=%b eq=%b exp cnt=2 fv=1 fvec=01 eq=0",
                     mismatch_cnt, first_valid, first_vec, equal);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_step_mode();
        int seen;
        fsel = 1'b0;
        step_mode = 1'b1;
        do_start();
        step_mode = 1'b0;
        repeat (22) @(posedge clk);
        #1;
        checks++;
        if ({vec_out, busy, done} !== {2'b00, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL st_wait got vec=%b busy=%b done=%b exp 00 1 0", vec_out, busy, done);
        end
        for (int i = 1; i <= 3; i++) begin
            step = 1'b1;
            @(posedge clk); #1;
            step = 1'b0;
            seen = 0;
            for (int k = 0; k < 10; k++) begin
                if (done) seen++;
                @(posedge clk); #1;
            end
            checks++;
            if (seen != (i == 3 ? 1 : 0)) begin
                errors++;
                $display("FAIL st_done step %0d got %0d exp %0d", i, seen, i == 3 ? 1 : 0);
            end
            checks++;
            if (vec_out !== 2'(i)) begin
                errors++;
                $display("FAIL st_vec step %0d got %0d exp %0d", i, vec_out, i);
            end
        end
        checks++;
        if ({equal, mismatch_cnt, busy} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL st_result got eq=%b cnt=%0d busy=%b exp 1 0 0", equal, mismatch_cnt, busy);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        fsel = 1'b1;
        do_start();
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if ({vec_out, mismatch_cnt, busy} !== {2'd2, 3'd1, 1'b1}) begin
            errors++;
            $display("FAIL rm_pre got vec=%0d cnt=%0d busy=%b exp 2 1 1", vec_out, mismatch_cnt, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({vec_out, busy, done, equal, mismatch_cnt, first_valid, first_vec} !== '0) begin
            errors++;
            $display("FAIL rm_async got %b exp 0",
                     {vec_out, busy, done, equal, mismatch_cnt, first_valid, first_vec});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fsel = 1'b0;
        do_start();
        cyc = 1;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 9 || {equal, mismatch_cnt, first_valid} !== {1'b1, 3'd0, 1'b0}) begin
            errors++;
            $display("FAIL rm_resweep got cyc=%0d eq=%b cnt=%0d exp cyc=9 eq=1 cnt=0",
                     cyc, equal, mismatch_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_restart_ignored();
        int dones;
        int dcyc;
        fsel = 1'b1;
        do_start();
        dones = 0;
        dcyc = 0;
        for (int k = 1; k <= 15; k++) begin
            if (done) begin dones++; dcyc = k; end
            start = (k == 3 || k == 9);
            @(posedge clk); #1;
        end
        start = 1'b0;
        checks++;
        if (dones != 1 || dcyc != 9) begin
            errors++;
            $display("FAIL ri_done got count=%0d cycle=%0d exp count=1 cycle=9", dones, dcyc);
        end
        checks++;
        if ({mismatch_cnt, first_vec, busy} !== {3'd2, 2'b01, 1'b0}) begin
            errors++;
            $display("FAIL ri_result got cnt=%0d fvec=%b busy=%b exp 2 01 0",
                     mismatch_cnt, first_vec, busy);
        end
    endtask

    task automatic test_n3_settle3();
        int cyc;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (cyc != 33) begin errors++; $display("FAIL n3_done_cycle got %0d exp 33", cyc); end
        checks++;
        if ({equal2, cnt2, first_valid2, vec2} !== {1'b1, 4'd0, 1'b0, 3'b111}) begin
            errors++;
            $display("FAIL n3_result got eq=%b cnt=%0d fv=%b vec=%b exp 1 0 0 111",
                     equal2, cnt2, first_valid2, vec2);
        end
    endtask

    initial begin
        test_reset();
        test_equal_freerun();
        test_mismatch();
        test_step_mode();
        test_reset_mid();
        test_restart_ignored();
        test_n3_settle3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
